mem_port_arbiter: RTL

- Shares one single-ported memory between two requesters: the core instruction-fetch path (IF) and the load/store data path (D).
- Sits between the RV32I core and the unified memory.
- One transaction outstanding at a time; requesters and memory all use valid/ready handshakes.
- Fixed priority to D, with starvation protection for IF and a response timeout.

---
 rtl/rv32i_mem_pkg.sv | 39 +++
 rtl/mem_port_arbiter_starve.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_mem_pkg
//  Purpose  : Shared types and defaults for the RV32I memory-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_mem_pkg;

    localparam int MEM_ADDR_W      = 32;
    localparam int MEM_DATA_W      = 32;
    localparam int MEM_BE_W        = MEM_DATA_W / 8;
    localparam int STARVE_MAX_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

    // Counter width able to hold values 0 .. n-1 (never narrower than one bit).
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_ctr
//  Purpose  : Fixed D-over-IF priority with a saturating IF starvation counter.
//  Revision : 1.0  initial release
// ============================================================================
module arb_starve_ctr
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic d_valid,
    input  logic grant_stb,
    output logic grant_if,
    output logic grant_d
);

    localparam int CNT_W = ctr_width(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    always_comb begin
        starved      = (starve_cnt_q == CNT_SAT);
        grant_if     = if_valid && (!d_valid || starved);
        grant_d      = d_valid && !grant_if;
        starve_cnt_d = starve_cnt_q;
        if (grant_stb) begin
            if (grant_if) begin
                starve_cnt_d = '0;
            end else if (grant_d && if_valid && !starved) begin
                // Only D grants that actually pass over a waiting fetch count.
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between instruction fetch (IF)
//             and load/store (D), one transaction in flight, with timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int STARVE_MAX  = STARVE_MAX_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_rdata,
    output logic                  if_rsp_err,
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic [DATA_W-1:0]     d_req_wdata,
    input  logic [DATA_W/8-1:0]   d_req_be,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_rdata,
    output logic                  d_rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    output logic                  busy
);

    localparam int TO_W = ctr_width(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_e      state_q,         state_d;
    owner_e          owner_q,         owner_d;
    mem_req_t        mem_req_q,       mem_req_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [TO_W-1:0] to_cnt_q,        to_cnt_d;

    logic grant_if;
    logic grant_d;
    logic in_idle;
    logic in_wait;
    logic accept;
    logic rsp_fire;
    logic timeout;
    logic rsp_done;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_req_valid),
        .d_valid   (d_req_valid),
        .grant_stb (accept),
        .grant_if  (grant_if),
        .grant_d   (grant_d)
    );

    // Every combinational output is qualified by rst so reset blanks them at once.
    always_comb begin
        in_idle  = (state_q == IDLE);
        in_wait  = (state_q == WAIT);
        accept   = rst && in_idle && (grant_if || grant_d);
        rsp_fire = rst && in_wait && mem_rsp_valid;
        timeout  = rst && in_wait && !mem_rsp_valid && (to_cnt_q == TO_LAST);
        rsp_done = rsp_fire || timeout;
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        mem_req_d       = mem_req_q;
        mem_req_valid_d = mem_req_valid_q;
        to_cnt_d        = to_cnt_q;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (accept) begin
                    state_d         = ISSUE;
                    mem_req_valid_d = 1'b1;
                    if (grant_d) begin
                        owner_d         = OWN_D;
                        mem_req_d.we    = d_req_we;
                        mem_req_d.addr  = MEM_ADDR_W'(d_req_addr);
                        mem_req_d.wdata = MEM_DATA_W'(d_req_wdata);
                        mem_req_d.be    = MEM_BE_W'(d_req_be);
                    end else begin
                        // Fetches always read the full word.
                        owner_d         = OWN_IF;
                        mem_req_d.we    = 1'b0;
                        mem_req_d.addr  = MEM_ADDR_W'(if_req_addr);
                        mem_req_d.wdata = '0;
                        mem_req_d.be    = '1;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                    to_cnt_d        = '0;
                end
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rsp_done) begin
                    state_d  = IDLE;
                    to_cnt_d = '0;
                end
            end
            default: begin
                state_d         = IDLE;
                mem_req_valid_d = 1'b0;
                to_cnt_d        = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IF;
            mem_req_q       <= '0;
            mem_req_valid_q <= 1'b0;
            to_cnt_q        <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            mem_req_q       <= mem_req_d;
            mem_req_valid_q <= mem_req_valid_d;
            to_cnt_q        <= to_cnt_d;
        end
    end

    always_comb begin
        if_req_ready = accept && grant_if;
        d_req_ready  = accept && grant_d;

        if_rsp_valid = rsp_done && (owner_q == OWN_IF);
        d_rsp_valid  = rsp_done && (owner_q == OWN_D);
        if_rsp_err   = if_rsp_valid && timeout;
        d_rsp_err    = d_rsp_valid && timeout;
        if_rsp_rdata = (if_rsp_valid && rsp_fire) ? mem_rsp_rdata : '0;
        d_rsp_rdata  = (d_rsp_valid && rsp_fire) ? mem_rsp_rdata : '0;

        mem_req_valid = mem_req_valid_q;
        mem_we        = mem_req_q.we;
        mem_addr      = mem_req_q.addr[ADDR_W-1:0];
        mem_wdata     = mem_req_q.wdata[DATA_W-1:0];
        mem_be        = mem_req_q.be[DATA_W/8-1:0];
        busy          = (state_q != IDLE);
    end

endmodule
`default_nettype wire
